// File: rtl/svc_uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and bit-period helper.
package svc_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam int UART_DATA_BITS = 8;

  // Bit period in clocks. The division truncates, so the line runs slightly fast.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/svc_sync_bit.sv
// Two-flop synchronizer for one asynchronous bit, with a selectable reset value.
module svc_sync_bit #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/svc_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a bit-period counter, one-byte
// valid/ready output buffer, framing and overrun error pulses.
module svc_uart_rx
  import svc_uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      urx_rx,
  output logic                      urx_valid,
  output logic [UART_DATA_BITS-1:0] urx_data,
  input  logic                      urx_ready,
  output logic                      urx_frame_err,
  output logic                      urx_overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $fatal(1, "svc_uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic rx_s;
  logic rx_prev;

  svc_sync_bit #(.RST_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (urx_rx),
    .q   (rx_s)
  );

  state_t                    state,     state_n;
  logic [CW-1:0]             clk_cnt,   clk_cnt_n;
  logic [2:0]                bit_cnt,   bit_cnt_n;
  logic [UART_DATA_BITS-1:0] shift,     shift_n;
  logic [UART_DATA_BITS-1:0] data_n;
  logic                      valid_n;
  logic                      frame_n;
  logic                      overrun_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      rx_prev       <= 1'b1;
      urx_data      <= '0;
      urx_valid     <= 1'b0;
      urx_frame_err <= 1'b0;
      urx_overrun   <= 1'b0;
    end else begin
      state         <= state_n;
      clk_cnt       <= clk_cnt_n;
      bit_cnt       <= bit_cnt_n;
      shift         <= shift_n;
      rx_prev       <= rx_s;
      urx_data      <= data_n;
      urx_valid     <= valid_n;
      urx_frame_err <= frame_n;
      urx_overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    data_n    = urx_data;
    valid_n   = urx_valid && !urx_ready;
    frame_n   = 1'b0;
    overrun_n = 1'b0;

    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (clk_cnt == HALF_M1) begin
          clk_cnt_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n = '0;
          shift_n   = {rx_s, shift[UART_DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) state_n = STOP;
          else                     bit_cnt_n = bit_cnt + 1'b1;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            // A byte landing in the same cycle as the acceptance replaces it.
            if (urx_valid && !urx_ready) begin
              overrun_n = 1'b1;
            end else begin
              data_n  = shift;
              valid_n = 1'b1;
            end
            state_n = IDLE;
          end else begin
            frame_n = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/svc_uart_rx.md
Name: svc_uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the SoC's uart_tx line.
- Oversamples the serial input with a bit-period counter and delivers each byte over a valid/ready stream.
- Flags framing and overrun errors.
- Used as a sim-side console decoder on the SoC uart_tx pin, and as the RX peripheral for future SoC builds.

Parameters:
- CLOCK_FREQ, 25_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: line rate in bit/s.
- CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (localparam): bit period in clocks, truncated. Elaboration fails with $fatal if it is below 4.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- urx_rx, input, 1: serial line, asynchronous to clk, idle high.
- urx_valid, output, 1: received byte available.
- urx_data, output, 8: received byte, stable while urx_valid.
- urx_ready, input, 1: consumer accepts the byte when urx_valid && urx_ready.
- urx_frame_err, output, 1: one-cycle pulse when the stop bit is sampled low.
- urx_overrun, output, 1: one-cycle pulse when a byte completes and the buffer is still occupied.

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-high.
- Reset values: urx_valid=0, urx_data=0, urx_frame_err=0, urx_overrun=0, state=IDLE, counters=0. Synchronizer flops reset to 1 (line idle).
- Synchronizer: urx_rx passes through 2 flops. All decisions use the synced value rx_s. The previous rx_s is kept for edge detection.
- IDLE: on the 1->0 transition of rx_s, clear bit_cnt and clk_cnt, then go to START.
- START:
  - Count to CLKS_PER_BIT/2-1 and sample rx_s.
  - rx_s=1: false start; return to IDLE with no output or error.
  - rx_s=0: clear clk_cnt, go to DATA.
- DATA:
  - Count to CLKS_PER_BIT-1 and sample rx_s into the shift register, LSB first.
  - After 8 samples, go to STOP; otherwise increment bit_cnt.
- STOP: count to CLKS_PER_BIT-1 and sample rx_s.
  - rx_s=1, buffer empty or being drained this cycle: load urx_data, set urx_valid on the next edge, go to IDLE.
  - rx_s=1, urx_valid && !urx_ready: pulse urx_overrun, drop the new byte, keep the old byte and valid, go to IDLE.
  - rx_s=0: pulse urx_frame_err, drop the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1 (break / stuck-low line), then go to IDLE. No start detection happens here.
- Handshake:
  - urx_valid stays high until accepted and clears the cycle after valid && ready.
  - urx_data must not change while valid is high, except when a new byte lands in the same cycle as the acceptance.
  - Same-cycle accept and new byte: the new byte loads, urx_valid stays 1, no overrun.
  - urx_ready is ignored while urx_valid=0.
- Latency: the stop bit is sampled 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the urx_rx falling edge. urx_valid rises 1 cycle later.
- Back-to-back frames: IDLE re-arms immediately after a good STOP sample, so a start bit beginning at the stop-bit boundary is caught with no gap.
- Reset mid-frame: aborts immediately and returns to IDLE. No partial byte is delivered, and no error pulse is raised.
- Widths: clk_cnt is $clog2(CLKS_PER_BIT) bits and bit_cnt is 3 bits. Neither wraps unintentionally; clk_cnt clears on every sample.

Decomposition:
- Package svc_uart_pkg:
  - state_t enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - UART_DATA_BITS=8.
  - Helper function clks_per_bit(freq, baud), shared with the UART transmitter.
- Sub-module svc_sync_bit:
  - Parameterised 2-flop synchronizer with a reset value parameter, here 1.
  - Instantiated once for urx_rx.

Test Plan (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, CLKS_PER_BIT=10):
- Single byte: drive 0xA5 as 8N1 with urx_ready=1 -> urx_valid for exactly 1 cycle with urx_data=0xA5, about 97 cycles after the falling edge; no error pulses.
- Backpressure/overrun: send 0x11 then 0x22 back-to-back with urx_ready=0 -> urx_data stays 0x11, urx_overrun pulses once at the second stop sample; raise ready -> 0x11 accepted, urx_valid drops.
- Same-cycle drain: hold ready=0 after 0x33, then assert ready in the exact cycle 0x44 completes -> no overrun, urx_valid stays 1, urx_data=0x44.
- Framing/break: send 0x55 with a low stop bit and hold the line low for 40 cycles -> urx_frame_err pulses once, no valid; after release, 0x0F is received correctly.
- Glitch: 3-cycle low pulse on an idle line -> false start, no valid, no errors; the next byte 0xC3 is received.
- Reset mid-frame: assert rst during bit 4 of 0xFF -> all outputs 0 immediately, no valid after release; the following 0x81 is received correctly.
